fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined ARMv8 core. It sits directly upstream of the instruction memory and owns the program counter. It drives the memory's byte address, captures the returned 32-bit instruction into the IF/ID pipeline register, and handles stall holds and branch redirects with a bubble insert.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// loads the IF/ID register, with stall holds and bubble-on-redirect.
module fetch_stage #(
    parameter int unsigned          addr_size = 64,
    parameter int unsigned          size      = 32,
    parameter logic [addr_size-1:0] reset_pc  = '0,
    parameter logic [size-1:0]      nop_word  = 32'hD503201F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [addr_size-1:0] branch_target,
    output logic [addr_size-1:0] imem_addr,
    input  logic [size-1:0]      imem_data,
    output logic [addr_size-1:0] ifid_pc,
    output logic [size-1:0]      ifid_instr,
    output logic                 ifid_valid,
    output logic [addr_size-1:0] ifid_pc_plus4,
    output logic [31:0]          fetch_count,
    output logic                 misalign
);

    typedef struct packed {
        logic [addr_size-1:0] pc;
        logic [addr_size-1:0] pc_plus4;
        logic [size-1:0]      instr;
        logic                 valid;
    } if_id_t;

    localparam logic [addr_size-1:0] pc_step = addr_size'(4);

    logic [addr_size-1:0] pc;
    logic [addr_size-1:0] pc_inc;
    logic [addr_size-1:0] target_aligned;
    if_id_t               if_id;
    logic [31:0]          count;
    logic                 mis_q;

    assign pc_inc         = pc + pc_step;
    assign target_aligned = {branch_target[addr_size-1:2], 2'b00};

    // Redirect outranks stall, so both may be high: priority, not unique.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= reset_pc;
            if_id.pc       <= '0;
            if_id.pc_plus4 <= '0;
            if_id.instr    <= nop_word;
            if_id.valid    <= 1'b0;
            count          <= '0;
            mis_q          <= 1'b0;
        end else begin
            priority case (1'b1)
                branch_taken: begin
                    pc          <= target_aligned;
                    if_id.instr <= nop_word;
                    if_id.valid <= 1'b0;
                    mis_q       <= mis_q | (branch_target[1:0] != 2'b00);
                end
                stall: begin
                end
                default: begin
                    pc             <= pc_inc;
                    if_id.pc       <= pc;
                    if_id.pc_plus4 <= pc_inc;
                    if_id.instr    <= imem_data;
                    if_id.valid    <= 1'b1;
                    count          <= count + 32'd1;
                end
            endcase
        end
    end

    assign imem_addr     = pc;
    assign ifid_pc       = if_id.pc;
    assign ifid_pc_plus4 = if_id.pc_plus4;
    assign ifid_instr    = if_id.instr;
    assign ifid_valid    = if_id.valid;
    assign fetch_count   = count;
    assign misalign      = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-edge stimulus and expected state,
// plus a wrap-around sequence on a second instance.
module tb_fetch_stage;

    localparam logic [31:0] nop = 32'hD503201F;
    localparam logic [63:0] top_pc = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr, ifid_pc, ifid_pc_plus4;
    logic [31:0] imem_data, ifid_instr, fetch_count;
    logic        ifid_valid, misalign;

    logic        w_reset, w_stall, w_br;
    logic [63:0] w_tgt;
    logic [63:0] w_addr, w_pc, w_p4;
    logic [31:0] w_data, w_instr, w_cnt;
    logic        w_valid, w_mis;

    always #5 clk = ~clk;

    // Memory holds word k at byte address 4k.
    assign imem_data = imem_addr[33:2];
    assign w_data    = w_addr[33:2];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .ifid_pc_plus4(ifid_pc_plus4),
        .fetch_count(fetch_count), .misalign(misalign)
    );

    fetch_stage #(.reset_pc(top_pc)) u_wrap (
        .clk(clk), .reset(w_reset), .stall(w_stall),
        .branch_taken(w_br), .branch_target(w_tgt),
        .imem_addr(w_addr), .imem_data(w_data),
        .ifid_pc(w_pc), .ifid_instr(w_instr),
        .ifid_valid(w_valid), .ifid_pc_plus4(w_p4),
        .fetch_count(w_cnt), .misalign(w_mis)
    );

    typedef struct {
        logic        rst, stl, br;
        logic [63:0] tgt;
        logic [63:0] addr, pc;
        logic [31:0] instr;
        logic        v;
        logic [63:0] p4;
        logic [31:0] cnt;
        logic        mis;
    } vec_t;

    localparam int nvec = 32;
    vec_t tbl[nvec];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic br,
        input logic [63:0] tgt, input logic [63:0] addr,
        input logic [63:0] pc, input logic [31:0] instr,
        input logic v, input logic [63:0] p4,
        input logic [31:0] cnt, input logic mis);
        vec_t r;
        r.rst = rst; r.stl = stl; r.br = br; r.tgt = tgt;
        r.addr = addr; r.pc = pc; r.instr = instr; r.v = v;
        r.p4 = p4; r.cnt = cnt; r.mis = mis;
        return r;
    endfunction

    task automatic chk(input string name, input int step,
                       input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h",
                     name, step, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        // Sequential fetch
        tbl[0]  = mk(1,0,0,0, 64'h00, 64'h00, nop, 0, 64'h00, 0, 0);
        tbl[1]  = mk(0,0,0,0, 64'h04, 64'h00, 0,   1, 64'h04, 1, 0);
        tbl[2]  = mk(0,0,0,0, 64'h08, 64'h04, 1,   1, 64'h08, 2, 0);
        tbl[3]  = mk(0,0,0,0, 64'h0C, 64'h08, 2,   1, 64'h0C, 3, 0);
        tbl[4]  = mk(0,0,0,0, 64'h10, 64'h0C, 3,   1, 64'h10, 4, 0);
        tbl[5]  = mk(0,0,0,0, 64'h14, 64'h10, 4,   1, 64'h14, 5, 0);
        tbl[6]  = mk(0,0,0,0, 64'h18, 64'h14, 5,   1, 64'h18, 6, 0);
        // Stall at PC=0x10
        tbl[7]  = mk(1,0,0,0, 64'h00, 64'h00, nop, 0, 64'h00, 0, 0);
        tbl[8]  = mk(0,0,0,0, 64'h04, 64'h00, 0,   1, 64'h04, 1, 0);
        tbl[9]  = mk(0,0,0,0, 64'h08, 64'h04, 1,   1, 64'h08, 2, 0);
        tbl[10] = mk(0,0,0,0, 64'h0C, 64'h08, 2,   1, 64'h0C, 3, 0);
        tbl[11] = mk(0,0,0,0, 64'h10, 64'h0C, 3,   1, 64'h10, 4, 0);
        tbl[12] = mk(0,1,0,0, 64'h10, 64'h0C, 3,   1, 64'h10, 4, 0);
        tbl[13] = mk(0,1,0,0, 64'h10, 64'h0C, 3,   1, 64'h10, 4, 0);
        tbl[14] = mk(0,1,0,0, 64'h10, 64'h0C, 3,   1, 64'h10, 4, 0);
        tbl[15] = mk(0,0,0,0, 64'h14, 64'h10, 4,   1, 64'h14, 5, 0);
        // Branch at PC=0x0C to 0x40
        tbl[16] = mk(1,0,0,0, 64'h00, 64'h00, nop, 0, 64'h00, 0, 0);
        tbl[17] = mk(0,0,0,0, 64'h04, 64'h00, 0,   1, 64'h04, 1, 0);
        tbl[18] = mk(0,0,0,0, 64'h08, 64'h04, 1,   1, 64'h08, 2, 0);
        tbl[19] = mk(0,0,0,0, 64'h0C, 64'h08, 2,   1, 64'h0C, 3, 0);
        tbl[20] = mk(0,0,1,64'h40, 64'h40, 64'h08, nop, 0, 64'h0C, 3, 0);
        tbl[21] = mk(0,0,0,0, 64'h44, 64'h40, 32'h10, 1, 64'h44, 4, 0);
        // Branch with stall, misaligned target, sticky flag
        tbl[22] = mk(0,1,1,64'h43, 64'h40, 64'h40, nop, 0, 64'h44, 4, 1);
        tbl[23] = mk(0,0,0,0, 64'h44, 64'h40, 32'h10, 1, 64'h44, 5, 1);
        tbl[24] = mk(0,0,1,64'h100, 64'h100, 64'h40, nop, 0, 64'h44, 5, 1);
        tbl[25] = mk(0,0,0,0, 64'h104, 64'h100, 32'h40, 1, 64'h104, 6, 1);
        tbl[26] = mk(0,0,0,0, 64'h108, 64'h104, 32'h41, 1, 64'h108, 7, 1);
        tbl[27] = mk(0,0,0,0, 64'h10C, 64'h108, 32'h42, 1, 64'h10C, 8, 1);
        tbl[28] = mk(0,0,0,0, 64'h110, 64'h10C, 32'h43, 1, 64'h110, 9, 1);
        // Reset during stall (and redirect) with fetch_count=9
        tbl[29] = mk(0,1,0,0, 64'h110, 64'h10C, 32'h43, 1, 64'h110, 9, 1);
        tbl[30] = mk(1,1,1,64'h203, 64'h00, 64'h00, nop, 0, 64'h00, 0, 0);
        tbl[31] = mk(0,0,0,0, 64'h04, 64'h00, 0,   1, 64'h04, 1, 0);

        reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
        w_reset = 1; w_stall = 0; w_br = 0; w_tgt = '0;

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            reset         = tbl[i].rst;
            stall         = tbl[i].stl;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].tgt;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("imem_addr", i, imem_addr, e.addr);
            chk("ifid_pc", i, ifid_pc, e.pc);
            chk("ifid_instr", i, {32'd0, ifid_instr}, {32'd0, e.instr});
            chk("ifid_valid", i, {63'd0, ifid_valid}, {63'd0, e.v});
            chk("ifid_pc_plus4", i, ifid_pc_plus4, e.p4);
            chk("fetch_count", i, {32'd0, fetch_count}, {32'd0, e.cnt});
            chk("misalign", i, {63'd0, misalign}, {63'd0, e.mis});
        end

        // PC wrap from the top of the address space
        @(negedge clk);
        w_reset = 0;
        chk("wrap_reset_addr", 100, w_addr, top_pc);
        chk("wrap_reset_valid", 100, {63'd0, w_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("wrap_addr", 101, w_addr, 64'd0);
        chk("wrap_ifid_pc", 101, w_pc, top_pc);
        chk("wrap_pc_plus4", 101, w_p4, 64'd0);
        chk("wrap_instr", 101, {32'd0, w_instr}, 64'hFFFF_FFFF);
        chk("wrap_count", 101, {32'd0, w_cnt}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
